// File: rtl/tt_um_jimktrains_vslc_servo.sv
// -----------------------------------------------------------------------------
// tt_um_jimktrains_vslc_servo
//
// Hobby-servo output stage for the VSLC core. Each rising edge of the core's
// scan-cycle level samples the logical command bits. A 0 steers its channel
// toward MIN_TICKS of pulse width and a 1 steers it toward MAX_TICKS. Width
// changes only at frame wrap, by at most STEP_TICKS per frame, so a servo
// ramps between its end stops instead of snapping.
//
// Ports:
//   clk          single clock
//   rst_n        synchronous active-low reset
//   ena          run enable; while low the frame timing and outputs are held
//                at zero, widths hold, and commands are still captured
//   cmd          logical command bits (core uo_out[CHANNELS-1:0])
//   scan_cycle   core scan-cycle level, synchronous to clk
//   servo_pwm    registered pulse outputs, one per channel
//   frame_start  one-clock pulse following each frame wrap
//   busy         high while any channel width differs from its target
// -----------------------------------------------------------------------------
module tt_um_jimktrains_vslc_servo #(
    parameter int SERVO_CLK_DIV = 10,
    parameter int CHANNELS      = 4,
    parameter int FRAME_TICKS   = 200,
    parameter int MIN_TICKS     = 10,
    parameter int MAX_TICKS     = 20,
    parameter int STEP_TICKS    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] cmd,
    input  logic                scan_cycle,
    output logic [CHANNELS-1:0] servo_pwm,
    output logic                frame_start,
    output logic                busy
);

    localparam int W        = $clog2(FRAME_TICKS + 1);
    localparam int PRE_W    = (SERVO_CLK_DIV == 0) ? 1 : SERVO_CLK_DIV;
    localparam int PRE_MAXI = (1 << SERVO_CLK_DIV) - 1;
    // A step larger than the frame can never be used; clamping keeps it in W bits.
    localparam int STEP_C   = (STEP_TICKS > FRAME_TICKS) ? FRAME_TICKS : STEP_TICKS;

    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(PRE_MAXI);
    localparam logic [W-1:0]     FRAME_LAST = W'(FRAME_TICKS - 1);
    localparam logic [W-1:0]     MIN_W      = W'(MIN_TICKS);
    localparam logic [W-1:0]     MAX_W      = W'(MAX_TICKS);
    localparam logic [W-1:0]     STEP_W     = W'(STEP_C);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [W-1:0]        fcnt_q, fcnt_d;
    logic                scan_prev_q, scan_prev_d;
    logic [W-1:0]        target_q [CHANNELS];
    logic [W-1:0]        target_d [CHANNELS];
    logic [W-1:0]        width_q  [CHANNELS];
    logic [W-1:0]        width_d  [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                frame_start_q, frame_start_d;

    logic tick;
    logic wrap;
    logic scan_rise;
    logic [W-1:0] gap;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        tick      = ena && (pre_q == PRE_MAX);
        wrap      = tick && (fcnt_q == FRAME_LAST);
        scan_rise = scan_cycle && !scan_prev_q;

        // With SERVO_CLK_DIV=0 the prescaler max is 0, so pre stays 0 and
        // tick is simply ena.
        pre_d = '0;
        if (ena && (pre_q != PRE_MAX)) begin
            pre_d = pre_q + PRE_W'(1);
        end

        fcnt_d = fcnt_q;
        if (!ena || wrap) begin
            fcnt_d = '0;
        end else if (tick) begin
            fcnt_d = fcnt_q + W'(1);
        end

        scan_prev_d   = scan_cycle;
        frame_start_d = wrap;
        pwm_d         = '0;
        busy          = 1'b0;
        gap           = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            // Capture only on the scan-cycle rising edge; a held level is ignored.
            target_d[i] = target_q[i];
            if (scan_rise) begin
                target_d[i] = cmd[i] ? MAX_W : MIN_W;
            end

            // Step toward the target as it stood before this edge, never past it.
            width_d[i] = width_q[i];
            if (wrap) begin
                if (target_q[i] > width_q[i]) begin
                    gap        = target_q[i] - width_q[i];
                    width_d[i] = width_q[i] + ((gap > STEP_W) ? STEP_W : gap);
                end else if (target_q[i] < width_q[i]) begin
                    gap        = width_q[i] - target_q[i];
                    width_d[i] = width_q[i] - ((gap > STEP_W) ? STEP_W : gap);
                end
            end

            pwm_d[i] = ena && (fcnt_q < width_q[i]);
            busy     = busy | (width_q[i] != target_q[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q         <= '0;
            fcnt_q        <= '0;
            scan_prev_q   <= 1'b0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            // NOTE: the per-channel arrays are control state, not storage, so
            // they are reset element by element like any other flop.
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= MIN_W;
                width_q[i]  <= MIN_W;
            end
        end else begin
            pre_q         <= pre_d;
            fcnt_q        <= fcnt_d;
            scan_prev_q   <= scan_prev_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= target_d[i];
                width_q[i]  <= width_d[i];
            end
        end
    end

    assign servo_pwm   = pwm_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_servo.sv
// -----------------------------------------------------------------------------
// Testbench for tt_um_jimktrains_vslc_servo.
// A reference model steps once per clock from the applied inputs and pushes
// the expected {servo_pwm, frame_start, busy} into a queue; a monitor pops
// and compares after every rising edge. A second monitor measures ch0 high
// time per frame for the directed ramp/reversal/coincidence scenarios.
// -----------------------------------------------------------------------------
module tb_tt_um_jimktrains_vslc_servo;

    localparam int DIV   = 0;
    localparam int CH    = 4;
    localparam int FRAME = 20;
    localparam int MINT  = 2;
    localparam int MAXT  = 6;
    localparam int STEP  = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [CH-1:0] cmd;
    logic          scan_cycle;
    logic [CH-1:0] servo_pwm;
    logic          frame_start;
    logic          busy;

    tt_um_jimktrains_vslc_servo #(
        .SERVO_CLK_DIV(DIV), .CHANNELS(CH), .FRAME_TICKS(FRAME),
        .MIN_TICKS(MINT), .MAX_TICKS(MAXT), .STEP_TICKS(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmd(cmd), .scan_cycle(scan_cycle),
        .servo_pwm(servo_pwm), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pre, m_fcnt, m_scan_prev;
    int m_target[CH];
    int m_width[CH];
    logic [CH+1:0] exp_q[$];
    bit sb_started = 0;
    bit done = 0;

    task automatic model_step();
        logic [CH-1:0] e_pwm;
        logic e_fs, e_busy;
        bit tick_now, wrap_now;
        int diff;
        e_pwm = '0;
        e_fs  = 1'b0;
        if (!rst_n) begin
            m_pre = 0; m_fcnt = 0; m_scan_prev = 0;
            for (int i = 0; i < CH; i++) begin
                m_target[i] = MINT;
                m_width[i]  = MINT;
            end
        end else begin
            tick_now = ena && (m_pre == (1 << DIV) - 1);
            wrap_now = tick_now && (m_fcnt == FRAME - 1);
            for (int i = 0; i < CH; i++) e_pwm[i] = ena && (m_fcnt < m_width[i]);
            e_fs = wrap_now;
            if (wrap_now) begin
                for (int i = 0; i < CH; i++) begin
                    diff = m_target[i] - m_width[i];
                    if (diff > 0) m_width[i] += (diff < STEP) ? diff : STEP;
                    else if (diff < 0) m_width[i] -= (-diff < STEP) ? -diff : STEP;
                end
            end
            if (scan_cycle && !m_scan_prev)
                for (int i = 0; i < CH; i++) m_target[i] = cmd[i] ? MAXT : MINT;
            m_scan_prev = scan_cycle;
            m_pre  = ena ? (m_pre + 1) % (1 << DIV) : 0;
            m_fcnt = !ena ? 0 : (tick_now ? (m_fcnt + 1) % FRAME : m_fcnt);
        end
        e_busy = 1'b0;
        for (int i = 0; i < CH; i++) if (m_width[i] != m_target[i]) e_busy = 1'b1;
        exp_q.push_back({e_pwm, e_fs, e_busy});
        sb_started = 1;
    endtask

    // Called at a falling edge with inputs already set: the model consumes
    // them for the coming rising edge, then we wait for the next falling edge.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic capture(input logic [CH-1:0] c);
        cmd = c; scan_cycle = 1'b1;
        step();
        scan_cycle = 1'b0;
    endtask

    // ---------------- monitors ----------------
    int hi_q[$];
    int exp_hi[$];
    int hi_cnt = 0;

    initial begin
        logic [CH+1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_started && !done) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_outputs", int'({servo_pwm, frame_start, busy}), int'(e));
                end
            end
            if (!rst_n) hi_cnt = 0;
            else if (frame_start) begin
                hi_q.push_back(hi_cnt);
                hi_cnt = 0;
            end else if (servo_pwm[0]) hi_cnt++;
        end
    end

    task automatic check_hi(input string name);
        check({name, "_frames"}, hi_q.size(), exp_hi.size());
        if (hi_q.size() == exp_hi.size())
            for (int i = 0; i < exp_hi.size(); i++)
                check($sformatf("%s_w%0d", name, i), hi_q[i], exp_hi[i]);
        hi_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst_n = 1'b0; ena = 1'b1; cmd = '0; scan_cycle = 1'b0;

        // 1. reset: three clocks low, then free-running MIN pulses.
        run(3);
        check("reset_pwm", int'(servo_pwm), 0);
        check("reset_fs", int'(frame_start), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        run(45);
        exp_hi = '{2, 2};
        check_hi("reset");

        // 2. ramp up ch0 with a one-clock scan pulse.
        capture(4'b0001);
        check("ramp_busy_rise", int'(busy), 1);
        run(100);
        exp_hi = '{2, 3, 4, 5, 6};
        check_hi("ramp");
        check("ramp_busy_low", int'(busy), 0);

        // 3. ramp down, then reverse mid-ramp at width 4 heading to 6.
        capture(4'b0000);
        run(100);
        exp_hi = '{6, 5, 4, 3, 2};
        check_hi("down");
        capture(4'b0001);
        run(40);
        exp_hi = '{2, 3};
        check_hi("up_part");
        check("rev_busy_mid", int'(busy), 1);
        capture(4'b0000);
        run(60);
        exp_hi = '{4, 3, 2};
        check_hi("reversal");
        check("rev_busy_low", int'(busy), 0);

        // 4. level hold: cmd changes while scan_cycle stays high are ignored.
        cmd = 4'b0000; scan_cycle = 1'b1;
        step();
        cmd = 4'b1111;
        run(3);
        check("hold_busy", int'(busy), 0);
        scan_cycle = 1'b0;
        step();
        scan_cycle = 1'b1;
        step();
        check("hold_new_edge", int'(busy), 1);
        scan_cycle = 1'b0;
        step();
        capture(4'b0000);
        run(100);
        check("hold_settle", int'(busy), 0);

        // 5a. drop ena mid-pulse, restart with width unchanged.
        guard = 0;
        while (m_fcnt != 1 && guard < 4 * FRAME) begin step(); guard++; end
        check("ena_align", m_fcnt, 1);
        check("ena_pulse_high", int'(servo_pwm[0]), 1);
        ena = 1'b0;
        step();
        check("ena_off_pwm", int'(servo_pwm), 0);
        run(7);
        ena = 1'b1;
        run(20);
        hi_q.delete();
        run(20);
        exp_hi = '{2};
        check_hi("ena_restart");

        // 5b. scan edge on a wrap clock: the step uses the old target.
        guard = 0;
        while (m_fcnt != FRAME - 1 && guard < 4 * FRAME) begin step(); guard++; end
        check("wrap_align", m_fcnt, FRAME - 1);
        capture(4'b0001);
        hi_q.delete();
        run(40);
        exp_hi = '{2, 3};
        check_hi("coincide");

        // 6. reset mid-ramp at width 4, target 6.
        check("midramp_busy", int'(busy), 1);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        check("rst_mid_busy", int'(busy), 0);
        hi_q.delete();
        run(40);
        exp_hi = '{2, 2};
        check_hi("after_reset");

        // A burst of random commands and scan pulses against the model.
        for (int k = 0; k < 300; k++) begin
            cmd        = CH'($urandom_range(0, 15));
            scan_cycle = ($urandom_range(0, 9) == 0);
            ena        = ($urandom_range(0, 49) != 0);
            step();
        end
        scan_cycle = 1'b0; ena = 1'b1;
        run(5);

        done = 1;
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
